// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register plus a FETCH/HOLD controller that parks
// a returned instruction while the pipeline is stalled, and handles redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        Branch,
  input  logic [31:0] BranchAddr,
  input  logic        Jump,
  input  logic [31:0] JumpAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCPlusOut,
  output logic [31:0] InstOut,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] hold_buf, hold_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        redirect;

  assign pc_plus4  = pc + 32'd4;
  assign redirect  = Branch | Jump;
  assign target    = Branch ? BranchAddr : JumpAddr;
  assign imem_addr = pc;
  assign PCPlusOut = pc_plus4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      state    <= FETCH;
      hold_buf <= '0;
    end else begin
      pc       <= pc_nxt;
      state    <= state_nxt;
      hold_buf <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    hold_nxt    = hold_buf;
    IF_ID_Write = 1'b0;
    IF_ID_Flush = 1'b0;
    imem_req    = (state == FETCH) && !rst;
    InstOut     = (state == HOLD) ? hold_buf : imem_rdata;

    // Reset gates every control output; redirect outranks any stall.
    if (!rst) begin
      if (redirect) begin
        pc_nxt      = target & ~32'd3;
        state_nxt   = FETCH;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b1;
      end else begin
        case (state)
          FETCH: begin
            if (imem_ready) begin
              if (PCWrite) begin
                IF_ID_Write = 1'b1;
                pc_nxt      = pc_plus4;
              end else begin
                hold_nxt  = imem_rdata;
                state_nxt = HOLD;
              end
            end else if (PCWrite) begin
              IF_ID_Write = 1'b1;
              IF_ID_Flush = 1'b1;
            end
          end
          HOLD: begin
            if (PCWrite) begin
              IF_ID_Write = 1'b1;
              pc_nxt      = pc_plus4;
              state_nxt   = FETCH;
            end
          end
          default: state_nxt = FETCH;
        endcase
      end
    end
  end

endmodule
